// File: rtl/router_input_port.sv
// router_input_port
//   One router input: buffers incoming flits in a small circular FIFO,
//   computes an XY (dimension-order) route for each head flit, and holds a
//   one-hot output request toward the input arbiter for the whole packet
//   (wormhole). On grant it dequeues one flit per cycle toward the crossbar
//   and returns a credit upstream for each dequeued flit.
//
// Ports
//   CLK        : clock, all state changes on the rising edge
//   RST_N      : synchronous reset, active-high despite the name
//   in_valid   : a flit is present on in_flit this cycle
//   in_flit    : incoming flit {head, tail, payload, dest_x, dest_y}
//   credit_out : one-cycle pulse for every flit handed to the crossbar
//   req        : one-hot request {west, south, east, north, local}
//   grant      : arbiter selected this input this cycle
//   out_valid  : out_flit carries a flit dequeued in the previous cycle
//   out_flit   : registered dequeued flit
//   count      : current FIFO occupancy
//   err        : sticky protocol error (overflow or headless flit in IDLE)

module router_input_port #(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 3,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     in_valid,
  input  logic [FLIT_W-1:0]        in_flit,
  output logic                     credit_out,
  output logic [4:0]               req,
  input  logic                     grant,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  // One-hot output port encodings
  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_NORTH = 5'b00010;
  localparam logic [4:0] P_EAST  = 5'b00100;
  localparam logic [4:0] P_SOUTH = 5'b01000;
  localparam logic [4:0] P_WEST  = 5'b10000;

  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [0:0]         state;
  logic [4:0]         route;

  logic [FLIT_W-1:0]  front;
  logic               front_head;
  logic               front_tail;
  logic [COORD_W-1:0] front_x;
  logic [COORD_W-1:0] front_y;
  logic               not_empty;
  logic               deq;
  logic               enq;
  logic               discard;
  logic               pop;
  logic               drop;
  logic               latch_route;
  logic [4:0]         route_calc;

  assign front      = mem[rd_ptr];
  assign front_head = front[FLIT_W-1];
  assign front_tail = front[FLIT_W-2];
  assign front_x    = front[2*COORD_W-1:COORD_W];
  assign front_y    = front[COORD_W-1:0];
  assign not_empty  = (count != '0);

  assign deq         = (state == S_ACTIVE) && grant && not_empty;
  // A full FIFO can still take a flit in the same cycle one leaves it.
  assign enq         = in_valid && ((count < FULL_CNT) || deq);
  assign drop        = in_valid && (count == FULL_CNT) && !deq;
  // A body/tail flit at the front while idle has no packet to belong to.
  assign discard     = (state == S_IDLE) && not_empty && !front_head;
  assign latch_route = (state == S_IDLE) && not_empty && front_head;
  assign pop         = deq || discard;

  // Request is asserted only while something is actually waiting, so the
  // arbiter sees a bubble as a dropped request rather than a stalled grant.
  assign req = ((state == S_ACTIVE) && not_empty) ? route : 5'b00000;

  // XY routing: resolve X first, then Y. The "less than" cases are written
  // as "not equal and not greater" so no compare folds to a constant when
  // the router sits at coordinate zero.
  always_comb begin
    route_calc = P_LOCAL;
    if (front_x > MY_X_C)
      route_calc = P_EAST;
    else if (front_x != MY_X_C)
      route_calc = P_WEST;
    else if (front_y > MY_Y_C)
      route_calc = P_NORTH;
    else if (front_y != MY_Y_C)
      route_calc = P_SOUTH;
  end

  // Flit storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (enq)
      mem[wr_ptr] <= in_flit;
  end

  // Pointers and occupancy. Pointers wrap naturally since DEPTH is a
  // power of two.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  // Packet state: a head at the front is routed while idle (no dequeue that
  // cycle); the tail leaving ends the packet.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state <= S_IDLE;
      route <= 5'b00000;
    end else begin
      if (latch_route) begin
        route <= route_calc;
        state <= S_ACTIVE;
      end else if (deq && front_tail) begin
        state <= S_IDLE;
      end
    end
  end

  // Output register and credit return. Discarded flits earn no credit.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      out_valid  <= 1'b0;
      out_flit   <= '0;
      credit_out <= 1'b0;
    end else begin
      out_valid  <= deq;
      credit_out <= deq;
      if (deq)
        out_flit <= front;
    end
  end

  // Sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST_N)
      err <= 1'b0;
    else if (drop || discard)
      err <= 1'b1;
  end

endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port
//   Directed bench for router_input_port with the router placed at (1,1).
//   Inputs are driven and outputs sampled on the falling clock edge, so each
//   sample shows the state produced by the preceding rising edge.

module tb_router_input_port;

  localparam int FLIT_W  = 32;
  localparam int DEPTH   = 4;
  localparam int COORD_W = 3;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              credit_out;
  logic [4:0]        req;
  logic              grant;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic [2:0]        count;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;

  router_input_port #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .COORD_W(COORD_W),
    .MY_X   (1),
    .MY_Y   (1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .credit_out(credit_out),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .count     (count),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  // Flit layout: {head, tail, 24-bit payload, dest_x, dest_y}
  function automatic logic [31:0] mk_flit(input logic head, input logic tail,
                                          input logic [23:0] payload,
                                          input logic [2:0] x, input logic [2:0] y);
    return {head, tail, payload, x, y};
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b1; in_valid = 1'b0; grant = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
  endtask

  // Reset with traffic on the input, then reset in the middle of a packet.
  task automatic test_reset();
    RST_N = 1'b1; grant = 1'b0; in_valid = 1'b1;
    in_flit = mk_flit(1'b1, 1'b0, 24'h000001, 3'd2, 3'd1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
    vectors++; if (req !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_req got %b expected 00000", req); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    vectors++; if (credit_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_credit got %b expected 0", credit_out); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b expected 0", err); end
    vectors++; if (out_flit !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_out_flit got %h expected 0", out_flit); end
    RST_N = 1'b0; in_valid = 1'b0;

    // Two flits buffered with no grant, then reset: all discarded, no credit.
    @(negedge CLK); in_valid = 1'b1; in_flit = mk_flit(1'b1, 1'b0, 24'h000002, 3'd2, 3'd1);
    @(negedge CLK); in_flit = mk_flit(1'b0, 1'b1, 24'h000003, 3'd2, 3'd1);
    @(negedge CLK); in_valid = 1'b0;
    vectors++; if (count !== 3'd2) begin miscompares++; $display("[TB] FAIL midreset_pre_count got %0d expected 2", count); end
    RST_N = 1'b1;
    @(negedge CLK); RST_N = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL midreset_count got %0d expected 0", count); end
    vectors++; if (req !== 5'b00000) begin miscompares++; $display("[TB] FAIL midreset_req got %b expected 00000", req); end
    grant = 1'b1;
    @(negedge CLK);
    vectors++; if (credit_out !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_credit got %b expected 0", credit_out); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_out_valid got %b expected 0", out_valid); end
    grant = 1'b0;
  endtask

  // Single-flit packets to each neighbour direction and to local.
  task automatic test_route();
    logic [2:0]  dest_x  [5] = '{3'd2, 3'd0, 3'd1, 3'd1, 3'd1};
    logic [2:0]  dest_y  [5] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd1};
    logic [4:0]  exp_req [5] = '{5'b00100, 5'b10000, 5'b00010, 5'b01000, 5'b00001};
    logic [31:0] f;
    int credits = 0;
    do_reset();
    grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f = mk_flit(1'b1, 1'b1, 24'h000100 + 24'(i), dest_x[i], dest_y[i]);
      @(negedge CLK);
      if (credit_out) credits++;
      in_valid = 1'b1; in_flit = f;
      @(negedge CLK);
      if (credit_out) credits++;
      in_valid = 1'b0;
      vectors++; if (req !== 5'b00000) begin miscompares++; $display("[TB] FAIL route%0d_req_early got %b expected 00000", i, req); end
      @(negedge CLK);
      if (credit_out) credits++;
      vectors++; if (req !== exp_req[i]) begin miscompares++; $display("[TB] FAIL route%0d_req got %b expected %b", i, req, exp_req[i]); end
      @(negedge CLK);
      if (credit_out) credits++;
      vectors++; if (out_valid !== 1'b1 || out_flit !== f) begin miscompares++; $display("[TB] FAIL route%0d_out got valid=%b flit=%h expected valid=1 flit=%h", i, out_valid, out_flit, f); end
      vectors++; if (req !== 5'b00000) begin miscompares++; $display("[TB] FAIL route%0d_req_after got %b expected 00000", i, req); end
    end
    vectors++; if (credits != 5) begin miscompares++; $display("[TB] FAIL route_credits got %0d expected 5", credits); end
    grant = 1'b0;
  endtask

  // 4-flit packet east, with the next packet's head queued behind its tail.
  task automatic test_wormhole();
    logic [31:0] pk [5];
    logic        drv_v   [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [4:0]  exp_req [10] = '{5'b00000, 5'b00000, 5'b00100, 5'b00100, 5'b00100,
                                  5'b00100, 5'b00000, 5'b10000, 5'b00000, 5'b00000};
    logic        exp_ov  [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 0};
    int          exp_idx [10] = '{0, 0, 0, 0, 1, 2, 3, 0, 4, 0};
    do_reset();
    pk[0] = mk_flit(1'b1, 1'b0, 24'h000200, 3'd3, 3'd0);
    pk[1] = mk_flit(1'b0, 1'b0, 24'h000201, 3'd3, 3'd0);
    pk[2] = mk_flit(1'b0, 1'b0, 24'h000202, 3'd3, 3'd0);
    pk[3] = mk_flit(1'b0, 1'b1, 24'h000203, 3'd3, 3'd0);
    pk[4] = mk_flit(1'b1, 1'b1, 24'h000204, 3'd0, 3'd1);
    grant = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      vectors++; if (req !== exp_req[c]) begin miscompares++; $display("[TB] FAIL worm_c%0d_req got %b expected %b", c, req, exp_req[c]); end
      vectors++; if (out_valid !== exp_ov[c]) begin miscompares++; $display("[TB] FAIL worm_c%0d_out_valid got %b expected %b", c, out_valid, exp_ov[c]); end
      if (exp_ov[c]) begin
        vectors++; if (out_flit !== pk[exp_idx[c]]) begin miscompares++; $display("[TB] FAIL worm_c%0d_out_flit got %h expected %h", c, out_flit, pk[exp_idx[c]]); end
      end
      in_valid = drv_v[c];
      if (c < 5) in_flit = pk[c];
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL worm_final_count got %0d expected 0", count); end
    grant = 1'b0;
  endtask

  // Fill, overflow, then stream with simultaneous enqueue/dequeue at full.
  task automatic test_full_wrap();
    logic [31:0] seq [12];
    logic [31:0] extra;
    do_reset();
    for (int i = 0; i < 4; i++)
      seq[i] = mk_flit(i == 0, 1'b0, 24'h000A00 + 24'(i), 3'd2, 3'd1);
    for (int i = 0; i < 8; i++)
      seq[4+i] = mk_flit(1'b0, i == 7, 24'h000B00 + 24'(i), 3'd2, 3'd1);
    extra = mk_flit(1'b0, 1'b0, 24'h000EEE, 3'd2, 3'd1);
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); in_valid = 1'b1; in_flit = seq[i];
    end
    @(negedge CLK);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_count got %0d expected 4", count); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL full_err_before got %b expected 0", err); end
    vectors++; if (req !== 5'b00100) begin miscompares++; $display("[TB] FAIL full_req got %b expected 00100", req); end
    in_flit = extra;
    @(negedge CLK);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_err got %b expected 1", err); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL overflow_count got %0d expected 4", count); end
    grant = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge CLK);
      if (k >= 1 && k <= 8) begin
        vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL wrap_k%0d_count got %0d expected 4", k, count); end
      end
      if (k >= 1 && k <= 12) begin
        vectors++; if (out_valid !== 1'b1 || out_flit !== seq[k-1]) begin miscompares++; $display("[TB] FAIL wrap_k%0d_out got valid=%b flit=%h expected valid=1 flit=%h", k, out_valid, out_flit, seq[k-1]); end
      end
      in_valid = (k < 8);
      if (k < 8) in_flit = seq[4+k];
    end
    vectors++; if (out_valid !== 1'b0 || count !== 3'd0 || req !== 5'b00000) begin miscompares++; $display("[TB] FAIL wrap_end got valid=%b count=%0d req=%b expected valid=0 count=0 req=00000", out_valid, count, req); end
    grant = 1'b0;
  endtask

  // Body flit arrives late: request drops while empty and comes back north.
  task automatic test_bubble();
    logic [31:0] h, b, t;
    logic [4:0]  exp_req [10] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000,
                                  5'b00010, 5'b00000, 5'b00010, 5'b00000, 5'b00000};
    logic        exp_ov  [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0};
    logic [31:0] exp_f   [10];
    do_reset();
    h = mk_flit(1'b1, 1'b0, 24'h000C00, 3'd1, 3'd2);
    b = mk_flit(1'b0, 1'b0, 24'h000C01, 3'd1, 3'd2);
    t = mk_flit(1'b0, 1'b1, 24'h000C02, 3'd1, 3'd2);
    exp_f = '{32'h0, 32'h0, 32'h0, h, 32'h0, 32'h0, b, 32'h0, t, 32'h0};
    grant = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      vectors++; if (req !== exp_req[c]) begin miscompares++; $display("[TB] FAIL bubble_c%0d_req got %b expected %b", c, req, exp_req[c]); end
      vectors++; if (out_valid !== exp_ov[c]) begin miscompares++; $display("[TB] FAIL bubble_c%0d_out_valid got %b expected %b", c, out_valid, exp_ov[c]); end
      if (exp_ov[c]) begin
        vectors++; if (out_flit !== exp_f[c]) begin miscompares++; $display("[TB] FAIL bubble_c%0d_out_flit got %h expected %h", c, out_flit, exp_f[c]); end
      end
      in_valid = (c == 0) || (c == 4) || (c == 6);
      if (c == 0) in_flit = h;
      if (c == 4) in_flit = b;
      if (c == 6) in_flit = t;
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL bubble_final_count got %0d expected 0", count); end
    grant = 1'b0;
  endtask

  // Headless flit while idle is thrown away without a credit; a following
  // proper packet still routes normally.
  task automatic test_protocol_err();
    logic [31:0] good;
    do_reset();
    grant = 1'b1;
    good = mk_flit(1'b1, 1'b1, 24'h000D01, 3'd1, 3'd1);
    @(negedge CLK);
    in_valid = 1'b1; in_flit = mk_flit(1'b0, 1'b1, 24'h000D00, 3'd2, 3'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    vectors++; if (count !== 3'd1 || req !== 5'b00000) begin miscompares++; $display("[TB] FAIL perr_c1 got count=%0d req=%b expected count=1 req=00000", count, req); end
    @(negedge CLK);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL perr_err got %b expected 1", err); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL perr_count got %0d expected 0", count); end
    vectors++; if (credit_out !== 1'b0 || req !== 5'b00000) begin miscompares++; $display("[TB] FAIL perr_c2 got credit=%b req=%b expected credit=0 req=00000", credit_out, req); end
    in_valid = 1'b1; in_flit = good;
    @(negedge CLK);
    in_valid = 1'b0;
    vectors++; if (credit_out !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL perr_c3 got credit=%b valid=%b expected credit=0 valid=0", credit_out, out_valid); end
    @(negedge CLK);
    vectors++; if (req !== 5'b00001) begin miscompares++; $display("[TB] FAIL perr_local_req got %b expected 00001", req); end
    @(negedge CLK);
    vectors++; if (out_valid !== 1'b1 || credit_out !== 1'b1 || out_flit !== good) begin miscompares++; $display("[TB] FAIL perr_recover got valid=%b credit=%b flit=%h expected valid=1 credit=1 flit=%h", out_valid, credit_out, out_flit, good); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL perr_sticky got %b expected 1", err); end
    grant = 1'b0;
  endtask

  initial begin
    RST_N = 1'b1; in_valid = 1'b0; grant = 1'b0; in_flit = '0;
    test_reset();
    test_route();
    test_wormhole();
    test_full_wrap();
    test_bubble();
    test_protocol_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/router_input_port.md
Name: router_input_port

Overview:
- One per router input, directly upstream of the router's static-priority input arbiter.
- Buffers incoming flits in a small FIFO and performs XY route computation on head flits.
- Presents a one-hot 5-bit output-port request vector to the arbiter, held for the whole packet (wormhole).
- On grant it dequeues one flit per cycle toward the crossbar and returns credits upstream.

Parameters:
- FLIT_W, 32, flit width. Bit FLIT_W-1 = head, FLIT_W-2 = tail, [2*COORD_W-1:COORD_W] = dest X, [COORD_W-1:0] = dest Y.
- DEPTH, 4, FIFO depth in flits (power of two, >=2).
- COORD_W, 3, width of each coordinate.
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous reset, active-high (asserted = 1), sampled on CLK.
- in_valid  in  1  flit present on in_flit this cycle.
- in_flit  in  FLIT_W  incoming flit.
- credit_out  out  1  one-cycle pulse per flit dequeued; returned upstream.
- req  out  5  one-hot output-port request to the arbiter. Bit 0 = local, 1 = north, 2 = east, 3 = south, 4 = west.
- grant  in  1  arbiter has selected this input for the requested output this cycle.
- out_valid  out  1  out_flit holds a dequeued flit.
- out_flit  out  FLIT_W  registered dequeued flit toward the crossbar.
- count  out  log2(DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky protocol error: overflow, or non-head flit arriving while idle.

Behaviour:
- Reset values while RST_N=1: FIFO empty, count=0, state IDLE, route register 0, req=0, out_valid=0, out_flit=0, credit_out=0, err=0.
  - Reset mid-packet discards all buffered flits.
  - No credits are issued for discarded flits.
- FIFO is a circular buffer with read/write pointers that wrap modulo DEPTH.
  - deq = (state==ACTIVE) && grant && (count!=0).
  - Enqueue is accepted iff in_valid && (count<DEPTH || deq).
  - A write at full with simultaneous deq is legal; count stays at DEPTH.
  - in_valid && count==DEPTH && !deq: flit dropped, err set.
  - Simultaneous enq and deq leaves count unchanged.
- States:
  - IDLE: if count!=0 and the front flit has head=1:
    - latch route into route register and go to ACTIVE next cycle; no dequeue this cycle.
    - If the front flit has head=0: pop and discard it, set err, issue no credit.
  - ACTIVE: on deq, if the dequeued flit has tail=1, return to IDLE next cycle. Otherwise stay in ACTIVE.
  - A flit with both head=1 and tail=1 is a single-flit packet.
- Route (XY, dimension-order, unsigned compare):
  - dx>MY_X → east; dx<MY_X → west.
  - Otherwise dy>MY_Y → north; dy<MY_Y → south.
  - Otherwise local.
- req = onehot(route register) when state==ACTIVE && count!=0, else 0.
  - req is combinational from registered state.
  - req drops while the FIFO is empty mid-packet and reasserts the same output when flits arrive.
- grant while req==0 is ignored.
- Latency:
  - Head arrival at the empty FIFO (cycle t) → written at t. IDLE sees it at t+1 → ACTIVE at t+2, req asserted at t+2.
  - deq at cycle t → out_flit/out_valid valid at t+1 and credit_out=1 at t+1.
  - out_valid=0 in any cycle following a cycle with no deq.
- Throughput: one flit per cycle while grant is held.

Test Plan:
- Reset: hold RST_N=1 for 2 cycles while driving in_valid=1 → count=0, req=0, out_valid=0, credit_out=0, err=0.
- Route, MY_X=1, MY_Y=1:
  - Single-flit packets to (2,1), (0,1), (1,2), (1,0), (1,1) with grant tied 1 → req sequence 00100, 10000, 00010, 01000, 00001.
  - 3 cycles from enqueue to first req; 5 credit pulses.
- Wormhole: 4-flit packet to (3,0), grant held 1 → req=00100 through the tail cycle, 4 consecutive out_valid cycles, then IDLE.
  - A following packet's head is not routed until after the tail leaves.
- Full/wrap: DEPTH=4, enqueue 4 flits with grant=0 → count=4. Drive a 5th in_valid with no grant → err=1, count=4.
  - Then stream 8 flits with grant=1 and continuous enqueue → pointers wrap, order preserved, count stays at 4.
- Bubble: 3-flit packet whose body flit arrives 3 cycles late → req drops to 0 while empty, reasserts the same bit, and the tail completes the packet.
- Protocol error: non-head flit arriving in IDLE → discarded, err=1, no credit_out pulse, req stays 0.
